call_stack_ctrl: RTL and testbench

- Hardware return-address stack controller for the 19-bit-instruction processor.
- Accepts the decoder's `push` (call) and `pop` (return) strobes and stores/returns 12-bit PC values.
- Sits between the instruction controller and the PC input mux, which selects `pop_addr` on a return.
- Tracks occupancy, detects overflow and underflow, and freezes in a fault state until software clears it.

---
 rtl/call_stack_ctrl.sv | 112 +++++++++++
 tb/tb_call_stack_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/call_stack_ctrl.sv
// Return-address stack: pop result registered one cycle after pop, no backpressure, faults freeze until clear_err.
// Push on full overwrites the oldest entry when CALL_STACK_WRAP_EN is defined, otherwise it raises overflow and faults.
module call_stack_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 12
) (
  input  logic                       clock,
  input  logic                       init_signal,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic                       clear_err,
  output logic [ADDR_W-1:0]          pop_addr,
  output logic                       pop_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       fault
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
`ifdef CALL_STACK_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic {OK, FAULT} state_t;
  state_t state;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     tp;
  logic [PW-1:0]     topIdx;
  logic [PW-1:0]     memWa;
  logic [ADDR_W-1:0] topData;
  logic              active;
  logic              pushOnly;
  logic              popOnly;
  logic              pushPop;
  logic              memWe;

  // clear_err outranks push/pop, and FAULT ignores both
  always_comb begin
    topIdx   = tp - 1'b1;
    topData  = mem[topIdx];
    active   = (state == OK) && !clear_err;
    pushOnly = active && push && !pop;
    popOnly  = active && pop && !push;
    pushPop  = active && push && pop;
    memWe    = (pushOnly && (!full || WRAP_EN)) || (pushPop && !empty);
    memWa    = pushPop ? topIdx : tp;
  end

  always_ff @(posedge clock) begin
    if (memWe) mem[memWa] <= push_addr;
  end

  always_ff @(posedge clock or posedge init_signal) begin
    if (init_signal) begin
      state     <= OK;
      tp        <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      pop_addr  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      fault     <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      if (clear_err) begin
        state     <= OK;
        overflow  <= 1'b0;
        underflow <= 1'b0;
        fault     <= 1'b0;
      end else if (pushPop) begin
        // top is replaced in place; on an empty stack the address passes straight through
        pop_valid <= 1'b1;
        pop_addr  <= empty ? push_addr : topData;
      end else if (pushOnly) begin
        if (!full) begin
          tp    <= tp + 1'b1;
          count <= count + 1'b1;
          empty <= 1'b0;
          full  <= (count == CW'(DEPTH-1));
        end else if (WRAP_EN) begin
          tp <= tp + 1'b1;
        end else begin
          overflow <= 1'b1;
          state    <= FAULT;
          fault    <= 1'b1;
        end
      end else if (popOnly) begin
        if (!empty) begin
          pop_addr  <= topData;
          pop_valid <= 1'b1;
          tp        <= topIdx;
          count     <= count - 1'b1;
          full      <= 1'b0;
          empty     <= (count == CW'(1));
        end else begin
          underflow <= 1'b1;
          state     <= FAULT;
          fault     <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_call_stack_ctrl.sv
// Bench for call_stack_ctrl: directed scenarios plus random traffic against a queue-based stack model.
module tb_call_stack_ctrl;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 12;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clock = 1'b0;
  logic              init_signal;
  logic              push;
  logic              pop;
  logic              clear_err;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W-1:0] pop_addr;
  logic              pop_valid;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;
  logic              fault;

  int checks   = 0;
  int failures = 0;

  // reference model: a queue whose back is the top of stack
  logic [ADDR_W-1:0] mq[$];
  logic [ADDR_W-1:0] mAddr;
  bit                mValid;
  bit                mOv;
  bit                mUn;
  bit                mFault;

  call_stack_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .init_signal(init_signal),
    .push       (push),
    .pop        (pop),
    .push_addr  (push_addr),
    .clear_err  (clear_err),
    .pop_addr   (pop_addr),
    .pop_valid  (pop_valid),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow),
    .fault      (fault)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mAddr  = '0;
    mValid = 1'b0;
    mOv    = 1'b0;
    mUn    = 1'b0;
    mFault = 1'b0;
  endtask

  task automatic modelStep(input bit p, input bit q, input logic [ADDR_W-1:0] a, input bit c);
    mValid = 1'b0;
    if (c) begin
      mFault = 1'b0;
      mOv    = 1'b0;
      mUn    = 1'b0;
    end else if (!mFault) begin
      if (p && q) begin
        mValid = 1'b1;
        if (mq.size() == 0) mAddr = a;
        else begin
          mAddr = mq.pop_back();
          mq.push_back(a);
        end
      end else if (p) begin
        if (mq.size() < DEPTH) mq.push_back(a);
        else begin
`ifdef CALL_STACK_WRAP_EN
          void'(mq.pop_front());
          mq.push_back(a);
`else
          mOv    = 1'b1;
          mFault = 1'b1;
`endif
        end
      end else if (q) begin
        if (mq.size() > 0) begin
          mAddr  = mq.pop_back();
          mValid = 1'b1;
        end else begin
          mUn    = 1'b1;
          mFault = 1'b1;
        end
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkVal({tag, ".pop_addr"},  pop_addr,  mAddr);
    checkVal({tag, ".pop_valid"}, pop_valid, mValid);
    checkVal({tag, ".count"},     count,     mq.size());
    checkVal({tag, ".empty"},     empty,     mq.size() == 0);
    checkVal({tag, ".full"},      full,      mq.size() == DEPTH);
    checkVal({tag, ".overflow"},  overflow,  mOv);
    checkVal({tag, ".underflow"}, underflow, mUn);
    checkVal({tag, ".fault"},     fault,     mFault);
  endtask

  task automatic cycle(input string tag, input bit p, input bit q, input logic [ADDR_W-1:0] a, input bit c);
    push      = p;
    pop       = q;
    push_addr = a;
    clear_err = c;
    @(posedge clock);
    modelStep(p, q, a, c);
    #1;
    checkAll(tag);
  endtask

  initial begin
    logic [ADDR_W-1:0] addr;
    init_signal = 1'b1;
    push        = 1'b0;
    pop         = 1'b0;
    clear_err   = 1'b0;
    push_addr   = '0;
    modelReset();
    #11;
    checkAll("reset");
    #1;
    init_signal = 1'b0;

    // LIFO order with one result per cycle
    cycle("lifo.push", 1, 0, 12'h010, 0);
    cycle("lifo.push", 1, 0, 12'h020, 0);
    cycle("lifo.push", 1, 0, 12'h030, 0);
    cycle("lifo.pop1", 0, 1, 12'h000, 0);
    checkVal("lifo.pop1.addr", pop_addr, 12'h030);
    cycle("lifo.pop2", 0, 1, 12'h000, 0);
    checkVal("lifo.pop2.addr", pop_addr, 12'h020);
    cycle("lifo.pop3", 0, 1, 12'h000, 0);
    checkVal("lifo.pop3.addr", pop_addr, 12'h010);
    checkVal("lifo.empty", empty, 1'b1);

    // underflow freezes until clear_err
    cycle("under.pop", 0, 1, 12'h000, 0);
    checkVal("under.fault", fault, 1'b1);
    checkVal("under.flag", underflow, 1'b1);
    cycle("under.push", 1, 0, 12'h055, 0);
    checkVal("under.count", count, 0);
    cycle("under.clear", 1, 1, 12'h066, 1);
    checkVal("under.cleared", {fault, underflow, overflow}, 3'b000);

    // fill past DEPTH
    for (int i = 0; i < DEPTH + 1; i++) begin
      addr = 12'h100 + 12'(i);
      cycle("fill", 1, 0, addr, 0);
    end
    checkVal("fill.count", count, DEPTH);
`ifdef CALL_STACK_WRAP_EN
    checkVal("fill.fault", fault, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      addr = 12'h108 - 12'(i);
      cycle("wrap.pop", 0, 1, 12'h000, 0);
      checkVal("wrap.pop.addr", pop_addr, addr);
    end
`else
    checkVal("fill.fault", fault, 1'b1);
    checkVal("fill.overflow", overflow, 1'b1);
    cycle("fill.clear", 0, 0, 12'h000, 1);
    cycle("fill.pop", 0, 1, 12'h000, 0);
    checkVal("fill.pop.addr", pop_addr, 12'h107);
`endif
    for (int i = 0; i < DEPTH && mq.size() > 0; i++) cycle("drain", 0, 1, 12'h000, 0);

    // simultaneous push and pop replace the top
    cycle("swap.push", 1, 0, 12'h0A0, 0);
    cycle("swap.both", 1, 1, 12'h0B0, 0);
    checkVal("swap.addr", pop_addr, 12'h0A0);
    checkVal("swap.count", count, 1);
    cycle("swap.pop", 0, 1, 12'h000, 0);
    checkVal("swap.pop.addr", pop_addr, 12'h0B0);

    // pass-through on an empty stack
    cycle("pass", 1, 1, 12'h3FF, 0);
    checkVal("pass.addr", pop_addr, 12'h3FF);
    checkVal("pass.valid", pop_valid, 1'b1);
    checkVal("pass.underflow", underflow, 1'b0);

    // reset between edges takes effect without a clock
    cycle("ar.push", 1, 0, 12'h111, 0);
    cycle("ar.push", 1, 0, 12'h222, 0);
    cycle("ar.push", 1, 0, 12'h333, 0);
    checkVal("ar.pre.count", count, 3);
    push = 1'b0;
    #2;
    init_signal = 1'b1;
    #1;
    modelReset();
    checkAll("areset");
    #2;
    init_signal = 1'b0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bit p, q, c;
      p    = $urandom_range(0, 99) < 55;
      q    = $urandom_range(0, 99) < 45;
      c    = mFault ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
      addr = ADDR_W'($urandom);
      cycle("rand", p, q, addr, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
